lane_serializer: RTL and testbench
==================================

# lane_serializer

Downstream consumer of the lane shifter: accepts one 50-bit word (10 lanes × 5 bits) already right-shifted by `shift` lanes, plus its legality flag, and emits the meaningful lanes one per beat on a 5-bit valid/ready stream. Lanes are emitted from lane 0 upward. Fill lanes (the top `shift` lanes) are never emitted. Words flagged illegal (shift 5..7) are discarded and reported.

## Interface
Parameters:
- `LANES`, 10, lanes per word
- `LANE_W`, 5, bits per lane
- `SHIFT_W`, 3, width of the shift amount
- `MAX_SHIFT`, 4, largest legal shift in lanes

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_word`  in  LANES*LANE_W  shifted word; lane k = bits [k*5+4 : k*5]
- `in_shift`  in  SHIFT_W  shift applied upstream, in lanes
- `in_legal`  in  1  legality flag from the shifter (1 = shift ≤ 4)
- `in_valid`  in  1  word handshake valid
- `in_ready`  out  1  word handshake ready
- `lane_data`  out  LANE_W  current lane
- `lane_idx`  out  4  index of the current lane (0..9)
- `lane_last`  out  1  current beat is the final lane of the word
- `lane_valid`  out  1  lane handshake valid
- `lane_ready`  in  1  lane handshake ready
- `drop`  out  1  one-cycle pulse: an illegal word was accepted and discarded
- `busy`  out  1  a word is held (state SEND)

## Operation
- States: IDLE, SEND. Reset → IDLE, `idx`=0, `cnt`=0, held word=0, `drop`=0.
- `in_ready` = (state==IDLE) | (state==SEND & `lane_last` & `lane_ready`). Forced to 0 while `rst`=1.
- Word accept = `in_valid` & `in_ready`.
  - If `in_legal`=0: the word is not stored and `drop`=1 on the next cycle. The next state is IDLE, also when the accept happened on the last beat of a word.
  - If `in_legal`=1: store the word, set `cnt` = LANES − `in_shift` (range 6..10), `idx`=0, next state SEND.
  - `in_shift` > MAX_SHIFT with `in_legal`=1 is an upstream fault. It is treated as illegal (dropped), so `cnt` is never below 6.
- SEND: `lane_valid`=1; `lane_data` = held word lane `idx`; `lane_idx`=`idx`; `lane_last` = (`idx`==`cnt`−1).
  - On `lane_valid` & `lane_ready` with `lane_last`=0: `idx` increments.
  - On `lane_valid` & `lane_ready` with `lane_last`=1:
    - with a simultaneous legal accept: reload the word, `cnt` and `idx`=0, stay in SEND;
    - otherwise: go to IDLE.
- IDLE: `lane_valid`, `lane_last` and `busy` are 0; `lane_data` and `lane_idx` are 0.
- While `lane_valid`=1 and `lane_ready`=0: `lane_data`, `lane_idx` and `lane_last` hold stable. `lane_valid` never drops without a handshake.
- Reset mid-word: the held word is abandoned and no further lanes are emitted. `lane_valid`=0 in the cycle after the reset edge.

## Timing
- Latency: word accepted at edge T → first lane valid after edge T (visible in cycle T+1).
- `drop` asserts in cycle T+1 for exactly one cycle per illegal accept.
- Throughput with `lane_ready` held at 1 is one lane per cycle, with no bubble between consecutive words. A word with shift s occupies exactly 10−s cycles.
- Outputs are driven from registered state. The only combinational path through the block is `lane_ready` → `in_ready`.

## Structure
- Shared package `lane_pkg`:
  - constants LANES, LANE_W, SHIFT_W, MAX_SHIFT;
  - the state enum {IDLE, SEND};
  - a function returning the lane count for a shift amount.
  The shifter and later stages import the same package.
- No sub-module. Lane selection is an indexed part-select of the held word.
- Expected size: about 150 lines of RTL.

## Test plan
- Reset, then one legal word, values below → 10 beats with `lane_data` 0..9 and `lane_last` only on idx 9; `in_ready` back to 1 after the last beat.
  - `in_shift`=0, lane k = k.
- Legal word with `in_shift`=4, lanes 0..5 = 0x1F,0x01,0x02,0x03,0x04,0x05 and fill lanes 6..9 = 0x0A → exactly 6 beats, last on idx 5; fill lanes never appear.
- `in_legal`=0 with `in_shift`=6 → no `lane_valid`; `drop`=1 for one cycle at T+1; `in_ready` stays 1.
- Back-to-back words (shift 2 then shift 3) with `lane_ready`=1 → 8 then 7 beats in 15 consecutive cycles; second accept coincides with the first word's last beat.
- Backpressure: drop `lane_ready` for 3 cycles at idx 4 → `lane_data` and `lane_idx` hold; no lane lost or duplicated; `in_ready`=0 throughout.
- Assert `rst` at idx 3 of a 10-lane word → `lane_valid`=0 next cycle, state IDLE; the following word starts at idx 0.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared constants, FSM state type and lane-count helper for the lane shifter
// and its downstream stages.
package lane_pkg;

  localparam int LANES     = 10;
  localparam int LANE_W    = 5;
  localparam int SHIFT_W   = 3;
  localparam int MAX_SHIFT = 4;
  localparam int IDX_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Meaningful lanes left after shifting right by `s` lanes.
  function automatic logic [IDX_W-1:0] lane_count(input logic [SHIFT_W-1:0] s);
    return IDX_W'(LANES) - IDX_W'(s);
  endfunction

endpackage

// File: rtl/lane_serializer.sv
// Serializes a shifted multi-lane word into one lane per beat on a valid/ready
// stream, skipping the fill lanes and discarding words flagged illegal.
module lane_serializer
  import lane_pkg::*;
#(
  parameter int LANES     = lane_pkg::LANES,
  parameter int LANE_W    = lane_pkg::LANE_W,
  parameter int SHIFT_W   = lane_pkg::SHIFT_W,
  parameter int MAX_SHIFT = lane_pkg::MAX_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] in_word,
  input  logic [SHIFT_W-1:0]      in_shift,
  input  logic                    in_legal,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANE_W-1:0]       lane_data,
  output logic [3:0]              lane_idx,
  output logic                    lane_last,
  output logic                    lane_valid,
  input  logic                    lane_ready,
  output logic                    drop,
  output logic                    busy
);

  ser_state_t              r_state, w_state_nxt;
  logic [LANES*LANE_W-1:0] r_word,  w_word_nxt;
  logic [3:0]              r_idx,   w_idx_nxt;
  logic [3:0]              r_cnt,   w_cnt_nxt;
  logic                    r_drop;

  logic w_send, w_last, w_accept, w_legal, w_load, w_beat;

  assign w_send = (r_state == SEND);
  assign w_last = w_send && (r_idx == (r_cnt - 4'd1));
  assign w_beat = w_send && lane_ready;

  // lane_ready -> in_ready is the only combinational path through the block.
  assign in_ready = !rst && (!w_send || (w_last && lane_ready));
  assign w_accept = in_valid && in_ready;
  // A shift beyond MAX_SHIFT claiming to be legal is an upstream fault; drop it
  // so the lane count never underflows its legal range.
  assign w_legal  = in_legal && (in_shift <= SHIFT_W'(MAX_SHIFT));
  assign w_load   = w_accept && w_legal;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt = SEND;
          w_word_nxt  = in_word;
          w_cnt_nxt   = lane_count(in_shift);
          w_idx_nxt   = '0;
        end
      end
      SEND: begin
        if (w_beat) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + 4'd1;
          end else if (w_load) begin
            w_word_nxt = in_word;
            w_cnt_nxt  = lane_count(in_shift);
            w_idx_nxt  = '0;
          end else begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drop  <= w_accept && !w_legal;
    end
  end

  assign lane_valid = w_send;
  assign lane_last  = w_last;
  assign lane_idx   = w_send ? r_idx : 4'd0;
  assign lane_data  = w_send ? r_word[LANE_W*r_idx +: LANE_W] : '0;
  assign drop       = r_drop;
  assign busy       = w_send;

endmodule

// File: tb/tb_lane_serializer.sv
// Scoreboard bench for lane_serializer: directed words push expected beats,
// a negedge monitor pops and compares every lane handshake.
module tb_lane_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [49:0] in_word;
  logic [2:0]  in_shift;
  logic        in_legal;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  lane_data;
  logic [3:0]  lane_idx;
  logic        lane_last;
  logic        lane_valid;
  logic        lane_ready;
  logic        drop;
  logic        busy;

  lane_serializer dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_shift(in_shift),
    .in_legal(in_legal), .in_valid(in_valid), .in_ready(in_ready),
    .lane_data(lane_data), .lane_idx(lane_idx), .lane_last(lane_last),
    .lane_valid(lane_valid), .lane_ready(lane_ready), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] data;
    logic [3:0] idx;
    logic       last;
  } beat_t;

  beat_t q[$];
  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every accepted lane must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && lane_valid && lane_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", {lane_idx, lane_data}, 32'hFFFF);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat", {lane_data, lane_idx, lane_last}, e);
      end
    end
  end

  function automatic logic [49:0] mk(input logic [4:0] l [10]);
    logic [49:0] w;
    for (int k = 0; k < 10; k++) w[k*5 +: 5] = l[k];
    return w;
  endfunction

  task automatic expect_word(input logic [4:0] l [10], input int n);
    for (int k = 0; k < n; k++) q.push_back({l[k], 4'(k), (k == n-1)});
  endtask

  // Present a word and hold it until the handshake completes.
  task automatic send(input logic [49:0] w, input logic [2:0] s, input logic lg);
    int n = 0;
    in_word = w; in_shift = s; in_legal = lg; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 50) begin chk("send_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk(nm, q.size(), 0);
  endtask

  logic [4:0] v1 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  logic [4:0] v2 [10] = '{5'h1F, 1, 2, 3, 4, 5, 5'h0A, 5'h0A, 5'h0A, 5'h0A};
  logic [4:0] v3 [10] = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18, 5'h0C, 5'h0C};
  logic [4:0] v4 [10] = '{5'h02, 5'h04, 5'h06, 5'h08, 5'h0A, 5'h0C, 5'h0E, 5'h1E, 5'h1E, 5'h1E};
  logic [4:0] v5 [10] = '{5'h01, 5'h04, 5'h07, 5'h0A, 5'h0D, 5'h10, 5'h13, 5'h16, 5'h19, 5'h1C};

  initial begin
    rst = 1'b1; in_word = '0; in_shift = '0; in_legal = 1'b0; in_valid = 1'b0;
    lane_ready = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", in_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", lane_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data_idx", {lane_data, lane_idx}, 0);
    @(posedge clk); #1;

    // Full 10-lane word.
    expect_word(v1, 10);
    send(mk(v1), 3'd0, 1'b1);
    drain("w1_drain");
    chk("w1_ready_after", in_ready, 1);
    chk("w1_busy_after", busy, 0);
    @(posedge clk); #1;

    // Shift 4: fill lanes must never be emitted.
    expect_word(v2, 6);
    send(mk(v2), 3'd4, 1'b1);
    drain("w2_drain");
    @(posedge clk); #1;

    // Illegal word, plus a legal-flagged shift beyond MAX_SHIFT.
    for (int t = 0; t < 2; t++) begin
      in_word = mk(v1); in_shift = (t == 0) ? 3'd6 : 3'd5;
      in_legal = (t != 0); in_valid = 1'b1;
      @(negedge clk);
      chk("drop_ready", in_ready, 1);
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      chk("drop_pulse", drop, 1);
      chk("drop_no_valid", lane_valid, 0);
      chk("drop_ready_after", in_ready, 1);
      @(negedge clk);
      chk("drop_one_cycle", drop, 0);
      chk("drop_no_valid2", lane_valid, 0);
      @(posedge clk); #1;
    end

    // Back-to-back shift 2 then shift 3: 15 gapless beats.
    begin
      int nv = 0;
      int acc_at = -1;
      logic w;
      expect_word(v3, 8);
      expect_word(v4, 7);
      in_word = mk(v3); in_shift = 3'd2; in_legal = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_word = mk(v4); in_shift = 3'd3;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (lane_valid) nv++;
        w = in_valid && in_ready;
        @(posedge clk); #1;
        if (w) begin in_valid = 1'b0; acc_at = i; end
      end
      chk("b2b_valid_cycles", nv, 15);
      chk("b2b_accept_on_last", acc_at, 7);
      @(negedge clk);
      chk("b2b_idle_after", lane_valid, 0);
      drain("b2b_drain");
    end
    @(posedge clk); #1;

    // Backpressure for 3 cycles at idx 4.
    begin
      int n = 0;
      expect_word(v5, 10);
      send(mk(v5), 3'd0, 1'b1);
      while (!(lane_valid && lane_idx == 4'd4) && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_reach_idx4", lane_idx, 4);
      lane_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("bp_hold", {lane_valid, lane_idx, lane_data}, {1'b1, 4'd4, 5'h0D});
        chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1; lane_ready = 1'b1;
      drain("bp_drain");
    end
    @(posedge clk); #1;

    // Reset at idx 3 abandons the word; the next word starts from idx 0.
    begin
      int n = 0;
      expect_word(v1, 10);
      send(mk(v1), 3'd0, 1'b1);
      while (!(lane_valid && lane_idx == 4'd3) && n < 20) begin @(posedge clk); #1; n++; end
      chk("rst_reach_idx3", lane_idx, 3);
      rst = 1'b1; lane_ready = 1'b0;
      @(negedge clk);
      chk("rst_forces_ready0", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      chk("rst_mid_valid", lane_valid, 0);
      chk("rst_mid_busy", busy, 0);
      lane_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_no_lanes", lane_valid, 0);
      expect_word(v2, 6);
      send(mk(v2), 3'd4, 1'b1);
      drain("post_rst_drain");
    end

    repeat (3) @(posedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
